// File: rtl/and_reduce_stream.sv
// and_reduce_stream
// Serial AND-reduction: operands arrive one per valid/ready handshake and
// one WIDTH-bit AND result per group leaves on a valid/ready output stream.
// A group is N operands. When the macro AND_STREAM_LAST_EN is defined, an
// in_last port is added and it can close a group early. out_count then
// reports the number of operands in the group, from 1 to N.
//
// state | meaning
// ------+------------------------------------------------------------
// ACC   | accepting operands into r_acc; r_cnt counts operands taken
// HOLD  | result presented on out_data/out_count until downstream takes it
module and_reduce_stream #(
  parameter int N     = 2,
  parameter int WIDTH = 1,
  localparam int CW   = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef AND_STREAM_LAST_EN
  input  logic             in_last,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CW-1:0] LP_CNT_LAST = CW'(N - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             w_close;

  // A group closes on its Nth operand, or early when in_last is set.
`ifdef AND_STREAM_LAST_EN
  assign w_close = (r_cnt == LP_CNT_LAST) | in_last;
`else
  assign w_close = (r_cnt == LP_CNT_LAST);
`endif

  // Group accumulator and handshake sequencing. The first operand loads r_acc
  // directly, so no all-ones seed value is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (in_valid) begin
            r_acc <= (r_cnt == '0) ? in_data : (r_acc & in_data);
            r_cnt <= r_cnt + CW'(1);
            if (w_close) r_state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state <= ACC;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

  // All outputs are decoded from registers only, so there is no
  // combinational path from the inputs to the outputs.
  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_acc;
  assign out_count = r_cnt;

endmodule
